// File: rtl/sn_grant_sched_pkg.sv
// Shared types and helpers for the sn/i grant scheduler.
//   state_t  : controller states (IDLE, RUN, DONE)
//   NUM_REQ  : number of requesters sharing the increment slot
//   rr_pick  : one-hot round-robin grant for two requesters
package sn_grant_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_REQ = 2;

  // ptr names the requester that wins when both request.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic               ptr);
    logic [NUM_REQ-1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sn_grant_sched_if.sv
// Command/status bundle of the sn/i grant scheduler.
//   master : drives start, abort, req; observes grant and run status/counters
//   slave  : the scheduler side
interface sn_grant_sched_if #(
  parameter int WIDTH = 8
);
  import sn_grant_sched_pkg::*;

  logic               start;
  logic               abort;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   i;
  logic [WIDTH-1:0]   sn;
  logic [WIDTH-1:0]   cnt0;
  logic [WIDTH-1:0]   cnt1;

  modport master (
    output start, abort, req,
    input  grant, busy, done, i, sn, cnt0, cnt1
  );

  modport slave (
    input  start, abort, req,
    output grant, busy, done, i, sn, cnt0, cnt1
  );

endinterface

// File: rtl/sn_grant_sched_rr_arb2.sv
// Two-way round-robin picker with its tie-break pointer.
//   clk, rst : clock, synchronous active-high reset (ptr -> 0)
//   en_i     : slot may be granted this cycle
//   req_i    : request vector
//   grant_o  : combinational one-hot grant (zero when en_i is low)
module rr_arb2
  import sn_grant_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = en_i ? rr_pick(req_i, ptr_q) : '0;
    ptr_d   = ptr_q;
    // After any grant, priority passes to the requester that did not win.
    if (grant_o != '0) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sn_grant_sched.sv
// Run sequencer and counters for the shared bounded sn/i increment slot.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/abort/req in; grant, busy, done, i, sn, cnt0, cnt1 out
// Optional: define SN_GRANT_SCHED_ASSERT_EN for simulation-only invariant
// assertions and a per-cycle trace; behaviour is identical either way.
//
// state | meaning
// IDLE  | waiting for start, counters held
// RUN   | granting the slot while i <= LIMIT
// DONE  | i reached LIMIT+1, counters frozen
module sn_grant_sched
  import sn_grant_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LIMIT = 200
) (
  input logic              clk,
  input logic              rst,
  sn_grant_sched_if.slave  bus
);

  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIMIT_P1 = WIDTH'(LIMIT + 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   i_q, i_d;
  logic [WIDTH-1:0]   sn_q, sn_d;
  logic [WIDTH-1:0]   cnt0_q, cnt0_d;
  logic [WIDTH-1:0]   cnt1_q, cnt1_d;
  logic               busy_q, done_q;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;

  // Reset and abort both block the slot in the cycle they are asserted.
  assign arb_en = (state_q == RUN) && !bus.abort && (i_q <= LIMIT_W) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .req_i   (bus.req),
    .grant_o (grant)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sn_d    = sn_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          i_d     = ONE_W;
          sn_d    = '0;
          cnt0_d  = '0;
          cnt1_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (grant != '0) begin
          i_d  = i_q + ONE_W;
          sn_d = sn_q + ONE_W;
          if (grant[0]) cnt0_d = cnt0_q + ONE_W;
          else          cnt1_d = cnt1_q + ONE_W;
          if (i_d == LIMIT_P1) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          i_d     = ONE_W;
          sn_d    = '0;
          cnt0_d  = '0;
          cnt1_d  = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= ONE_W;
      sn_q    <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sn_q    <= sn_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.grant = grant;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.i     = i_q;
  assign bus.sn    = sn_q;
  assign bus.cnt0  = cnt0_q;
  assign bus.cnt1  = cnt1_q;

`ifdef SN_GRANT_SCHED_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      assert (sn_q == i_q - ONE_W)
        else $error("sn_grant_sched: sn != i-1 (sn=%0d i=%0d)", sn_q, i_q);
      assert (WIDTH'(cnt0_q + cnt1_q) == sn_q)
        else $error("sn_grant_sched: cnt0+cnt1 != sn");
      assert (i_q >= ONE_W && i_q <= LIMIT_P1)
        else $error("sn_grant_sched: i out of range (%0d)", i_q);
      assert (grant != 2'b11)
        else $error("sn_grant_sched: both grant bits set");
      assert (grant == '0 || (state_q == RUN && i_q <= LIMIT_W))
        else $error("sn_grant_sched: grant outside open RUN slot");
      assert (!done_q || i_q == LIMIT_P1)
        else $error("sn_grant_sched: done with i=%0d", i_q);
      $display("sn_grant_sched: state=%s i=%0d sn=%0d cnt0=%0d cnt1=%0d",
               state_q.name(), i_q, sn_q, cnt0_q, cnt1_q);
    end
  end
`endif

endmodule

// File: tb/tb_sn_grant_sched.sv
module tb_sn_grant_sched;
  import sn_grant_sched_pkg::*;

  localparam int WIDTH = 8;
  localparam int LIMIT = 200;

  typedef struct {
    logic [1:0] grant;
    int         i;
    int         sn;
    int         c0;
    int         c1;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model state (0=IDLE 1=RUN 2=DONE)
  int   m_st, m_i, m_sn, m_c0, m_c1;
  logic m_ptr;

  sn_grant_sched_if #(.WIDTH(WIDTH)) sif ();

  sn_grant_sched #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive inputs, predict, compare grant and post-edge state.
  task automatic step(input logic s, input logic a, input logic [1:0] r, input logic rs);
    exp_t       e;
    exp_t       got;
    logic [1:0] g_seen;
    int         w;
    @(negedge clk);
    sif.start = s;
    sif.abort = a;
    sif.req   = r;
    rst       = rs;
    e.grant = 2'b00;
    if (rs) begin
      m_st = 0; m_i = 1; m_sn = 0; m_c0 = 0; m_c1 = 0; m_ptr = 1'b0;
    end else if (m_st == 0) begin
      if (s && !a) begin
        m_st = 1; m_i = 1; m_sn = 0; m_c0 = 0; m_c1 = 0;
      end
    end else if (m_st == 1) begin
      if (a) m_st = 0;
      else if (m_i <= LIMIT && r != 2'b00) begin
        if (r == 2'b11) w = int'(m_ptr);
        else            w = r[1] ? 1 : 0;
        e.grant = (w == 1) ? 2'b10 : 2'b01;
        m_i++;
        m_sn++;
        if (w == 1) m_c1++; else m_c0++;
        m_ptr = (w == 0);
        if (m_i == LIMIT + 1) m_st = 2;
      end
    end else begin
      if (a) m_st = 0;
      else if (s) begin
        m_st = 1; m_i = 1; m_sn = 0; m_c0 = 0; m_c1 = 0;
      end
    end
    e.i = m_i; e.sn = m_sn; e.c0 = m_c0; e.c1 = m_c1;
    e.busy = (m_st == 1);
    e.done = (m_st == 2);
    sb_q.push_back(e);
    #1 g_seen = sif.grant;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("grant", 32'(g_seen), 32'(got.grant));
      check("i",     32'(sif.i),    32'(got.i));
      check("sn",    32'(sif.sn),   32'(got.sn));
      check("cnt0",  32'(sif.cnt0), 32'(got.c0));
      check("cnt1",  32'(sif.cnt1), 32'(got.c1));
      check("busy",  32'(sif.busy), 32'(got.busy));
      check("done",  32'(sif.done), 32'(got.done));
    end
  endtask

  task automatic check_cnt(input string tag, input int i, input int sn, input int c0,
                           input int c1, input logic busy, input logic done);
    check({tag, "_i"},    32'(sif.i),    32'(i));
    check({tag, "_sn"},   32'(sif.sn),   32'(sn));
    check({tag, "_cnt0"}, 32'(sif.cnt0), 32'(c0));
    check({tag, "_cnt1"}, 32'(sif.cnt1), 32'(c1));
    check({tag, "_busy"}, 32'(sif.busy), 32'(busy));
    check({tag, "_done"}, 32'(sif.done), 32'(done));
  endtask

  initial begin
    int d;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.req   = 2'b00;
    m_st = 0; m_i = 1; m_sn = 0; m_c0 = 0; m_c1 = 0; m_ptr = 1'b0;

    // Reset
    step(0, 0, 2'b11, 1);
    step(0, 0, 2'b11, 1);
    check_cnt("reset", 1, 0, 0, 0, 0, 0);
    step(0, 0, 2'b11, 0);
    check("idle_grant", 32'(sif.grant), 32'd0);

    // Full run with both requesting
    step(1, 0, 2'b00, 0);
    check_cnt("started", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < LIMIT; k++) step(0, 0, 2'b11, 0);
    check_cnt("full_run", 201, 200, 100, 100, 0, 1);
    step(0, 0, 2'b11, 0);
    check("done_grant", 32'(sif.grant), 32'd0);

    // start+abort together in DONE: abort wins
    step(1, 1, 2'b00, 0);
    check_cnt("done_abort", 201, 200, 100, 100, 0, 0);

    // Single requesters
    step(1, 0, 2'b00, 0);
    for (int k = 0; k < 50; k++) step(0, 0, 2'b01, 0);
    for (int k = 0; k < 30; k++) step(0, 0, 2'b10, 0);
    check_cnt("single", 81, 80, 50, 30, 1, 0);

    // Abort mid-run, then restart
    step(0, 1, 2'b11, 0);
    step(1, 0, 2'b00, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 2'b11, 0);
    step(0, 1, 2'b11, 0);
    check_cnt("abort", 11, 10, 5, 5, 0, 0);
    step(1, 0, 2'b00, 0);
    check_cnt("restart", 1, 0, 0, 0, 1, 0);

    // Reset mid-run
    for (int k = 0; k < 77; k++) step(0, 0, 2'b11, 0);
    check("pre_rst_sn", 32'(sif.sn), 32'd77);
    step(0, 0, 2'b11, 1);
    check_cnt("mid_rst", 1, 0, 0, 0, 0, 0);
    step(0, 0, 2'b11, 0);
    check("post_rst_grant", 32'(sif.grant), 32'd0);

    // Toggling requests, start ignored in RUN, fairness throughout
    step(1, 0, 2'b00, 0);
    for (int k = 0; k < 40; k++) begin
      step((k == 7), 0, (k % 2 == 0) ? 2'b00 : 2'b11, 0);
      d = int'(sif.cnt0) - int'(sif.cnt1);
      check("fair", 32'((d <= 1) && (d >= -1)), 32'd1);
    end
    check_cnt("toggle", 21, 20, 10, 10, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
